// File: rtl/conv3x3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// conv3x3_seq_ctrl
//
// Sequencer for the 3x3 convolution datapath. That datapath is made of nine
// pipelined 16-bit multipliers feeding a binary adder tree, and it has no
// enable or stall.
//
// Frame flow: IDLE -> LOAD_K -> RUN -> DRAIN -> DONE -> IDLE.
//   - On start, nine kernel weights (k0..k8) are written into a held 144-bit bus.
//   - One 3x3 window per output position is then accepted from the line buffer.
//   - The fixed datapath latency is tracked so each result is tagged with its
//     row/col and a valid strobe.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Ready is driven by this block and depends only on the
// registered state, never on valid. Valid may be raised and dropped freely by
// the source; a cycle with valid low simply transfers nothing.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous reset, active low
//   start      in   1    request to begin a frame (honoured only in IDLE)
//   kw_valid   in   1    weight word valid
//   kw_data    in   16   weight word, arriving in order k0..k8
//   kw_ready   out  1    high throughout LOAD_K
//   win_valid  in   1    line buffer presents a window on the datapath x bus
//   win_ready  out  1    high throughout RUN
//   kernel     out  144  weight bus; word i on [16*i+15:16*i]
//   mac_issue  out  1    window enters the datapath this cycle
//   out_valid  out  1    datapath output is a valid result this cycle
//   out_row    out  CW   row of the current result
//   out_col    out  CW   column of the current result
//   busy       out  1    high in every state except IDLE
//   done       out  1    one-cycle pulse after the last result has left
// -----------------------------------------------------------------------------
module conv3x3_seq_ctrl #(
  parameter int OUT_W = 8,
  parameter int OUT_H = 8,
  parameter int LAT   = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          kw_valid,
  input  logic [15:0]   kw_data,
  output logic          kw_ready,
  input  logic          win_valid,
  output logic          win_ready,
  output logic [143:0]  kernel,
  output logic          mac_issue,
  output logic          out_valid,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_K = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(OUT_H - 1);

  state_t        state;
  logic [3:0]    k_idx;
  logic [CW-1:0] iss_row;
  logic [CW-1:0] iss_col;
  logic [LAT:1]  lat_sr;

  logic kw_hs;
  logic last_issue;
  logic last_result;

  // win_ready is only ever high in RUN, so a window handshake is an issue.
  assign mac_issue = win_valid & win_ready;
  assign kw_hs     = kw_valid & kw_ready;

  // The datapath cannot stall, so the result for an issue appears exactly LAT
  // cycles later. Bubbles in the issue stream are therefore carried through.
  assign out_valid = lat_sr[LAT];

  assign last_issue  = mac_issue && (iss_row == LAST_ROW) && (iss_col == LAST_COL);
  assign last_result = out_valid && (out_row == LAST_ROW) && (out_col == LAST_COL);

  // ---------------------------------------------------------------------------
  // Control FSM. Ready, busy and done are registered alongside the state, so
  // they change on the same edges as the state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_idx     <= '0;
      kernel    <= '0;
      kw_ready  <= 1'b0;
      win_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_K;
            k_idx    <= '0;
            kw_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_LOAD_K: begin
          if (kw_hs) begin
            kernel[16*k_idx +: 16] <= kw_data;
            if (k_idx == 4'd8) begin
              state     <= S_RUN;
              kw_ready  <= 1'b0;
              win_ready <= 1'b1;
            end else begin
              k_idx <= k_idx + 4'd1;
            end
          end
        end

        S_RUN: begin
          if (last_issue) begin
            state     <= S_DRAIN;
            win_ready <= 1'b0;
          end
        end

        S_DRAIN: begin
          // Leave on the same edge that retires the final result.
          if (last_result) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here; a new frame needs IDLE.
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          kw_ready  <= 1'b0;
          win_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue position counter (raster order). After the final window it wraps
  // back to (0,0), ready for the next frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_row <= '0;
      iss_col <= '0;
    end else if (mac_issue) begin
      if (iss_col == LAST_COL) begin
        iss_col <= '0;
        iss_row <= (iss_row == LAST_ROW) ? '0 : iss_row + 1'b1;
      end else begin
        iss_col <= iss_col + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Latency tracker: one bit per pipeline stage of the datapath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_sr <= '0;
    end else begin
      lat_sr[1] <= mac_issue;
      for (int i = 2; i <= LAT; i++) begin
        lat_sr[i] <= lat_sr[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result position counter. It is kept separate from the issue counter
  // because the two are LAT cycles apart and bubbles may fall in between.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row <= '0;
      out_col <= '0;
    end else if (out_valid) begin
      if (out_col == LAST_COL) begin
        out_col <= '0;
        out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
      end else begin
        out_col <= out_col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for conv3x3_seq_ctrl.
//
// The main instance is 4x4 with LAT=4. A 1x1, LAT=1 instance covers the
// single-window corner case.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge. Every window the bench offers during RUN is expected to
// issue in that same cycle. Its result is expected LAT cycles later, at the
// next raster position.
// -----------------------------------------------------------------------------
module tb_conv3x3_seq_ctrl;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int L   = 4;
  localparam int CWB = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // main instance signals
  logic           start, kw_valid, win_valid;
  logic [15:0]    kw_data;
  logic           kw_ready, win_ready, mac_issue, out_valid, busy, done;
  logic [143:0]   kernel;
  logic [CWB-1:0] out_row, out_col;

  // 1x1 instance signals
  logic           s_start, s_kw_valid, s_win_valid;
  logic [15:0]    s_kw_data;
  logic           s_kw_ready, s_win_ready, s_mac_issue, s_out_valid, s_busy, s_done;
  logic [143:0]   s_kernel;
  logic [0:0]     s_out_row, s_out_col;

  conv3x3_seq_ctrl #(.OUT_W(W), .OUT_H(H), .LAT(L), .CW(CWB)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .kw_valid(kw_valid), .kw_data(kw_data), .kw_ready(kw_ready),
    .win_valid(win_valid), .win_ready(win_ready), .kernel(kernel),
    .mac_issue(mac_issue), .out_valid(out_valid), .out_row(out_row),
    .out_col(out_col), .busy(busy), .done(done)
  );

  conv3x3_seq_ctrl #(.OUT_W(1), .OUT_H(1), .LAT(1), .CW(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .kw_valid(s_kw_valid), .kw_data(s_kw_data), .kw_ready(s_kw_ready),
    .win_valid(s_win_valid), .win_ready(s_win_ready), .kernel(s_kernel),
    .mac_issue(s_mac_issue), .out_valid(s_out_valid), .out_row(s_out_row),
    .out_col(s_out_col), .busy(s_busy), .done(s_done)
  );

  // scoreboard / reference model state
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            res_k = 0;        // raster index of the next expected result
  int            done_cyc = -1;    // cycle in which done must pulse
  logic [31:0]   exp_q[$];         // cycles in which out_valid must be high
  logic [15:0]   wts[9];
  logic [143:0]  exp_kernel = '0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  // Per-cycle result check against the expected-result queue.
  task automatic check_results();
    bit ov_exp;
    ov_exp = (exp_q.size() > 0) && (exp_q[0] == 32'(cyc));
    chk("out_valid", out_valid, ov_exp);
    if (ov_exp) begin
      void'(exp_q.pop_front());
      chk("out_row", out_row, res_k / W);
      chk("out_col", out_col, res_k % W);
      res_k++;
      if (res_k == W * H) begin
        res_k    = 0;
        done_cyc = cyc + 1;
      end
    end
    chk("done", done, cyc == done_cyc);
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_results();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_kernel"}, kernel, 144'd0);
    chk({tag, "_kw_ready"}, kw_ready, 1'b0);
    chk({tag, "_win_ready"}, win_ready, 1'b0);
    chk({tag, "_mac_issue"}, mac_issue, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_out_row"}, out_row, 0);
    chk({tag, "_out_col"}, out_col, 0);
  endtask

  task automatic set_weights(input bit seq);
    for (int i = 0; i < 9; i++) wts[i] = seq ? 16'(i + 1) : 16'($urandom);
  endtask

  // Start pulse in IDLE, then nine weight handshakes with random kw_valid gaps.
  task automatic load_kernel(input bit poke);
    int hs = 0;
    start = 1'b1;
    at_neg();
    chk("start_idle_busy", busy, 1'b0);
    next();
    start = 1'b0;
    for (int t = 0; t < 200 && hs < 9; t++) begin
      kw_valid = ($urandom_range(0, 2) != 0);
      kw_data  = wts[hs];
      start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      at_neg();
      chk("load_kw_ready", kw_ready, 1'b1);
      chk("load_win_ready", win_ready, 1'b0);
      chk("load_busy", busy, 1'b1);
      if (kw_valid) hs++;
      next();
    end
    kw_valid = 1'b0;
    start    = 1'b0;
    chk("load_hs_count", hs, 9);
    for (int i = 0; i < 9; i++) exp_kernel[16*i +: 16] = wts[i];
  endtask

  // Offer windows until n are accepted. While in RUN, stray weight traffic
  // must not touch the kernel.
  task automatic issue_windows(input int n, input bit bubbles, input bit poke);
    int got = 0;
    for (int t = 0; t < 400 && got < n; t++) begin
      win_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      kw_valid  = 1'($urandom_range(0, 1));
      kw_data   = 16'($urandom);
      start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      at_neg();
      if (t == 0) chk("kernel_loaded", kernel, exp_kernel);
      chk("run_win_ready", win_ready, 1'b1);
      chk("run_kw_ready", kw_ready, 1'b0);
      chk("mac_issue", mac_issue, win_valid);
      if (win_valid) begin
        exp_q.push_back(32'(cyc + L));
        got++;
      end
      next();
    end
    win_valid = 1'b0;
    kw_valid  = 1'b0;
    start     = 1'b0;
    chk("issue_count", got, n);
  endtask

  // Wait out the pipeline, then check the DONE cycle and the return to IDLE.
  task automatic drain_and_finish(input bit poke);
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) begin
      win_valid = 1'($urandom_range(0, 1));
      start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      at_neg();
      chk("drain_win_ready", win_ready, 1'b0);
      chk("drain_mac_issue", mac_issue, 1'b0);
      chk("drain_busy", busy, 1'b1);
      next();
    end
    chk("drain_pending", exp_q.size(), 0);
    win_valid = 1'b0;
    start     = poke;
    at_neg();
    chk("done_busy", busy, 1'b1);
    chk("done_row", out_row, 0);
    chk("done_col", out_col, 0);
    next();
    start = 1'b0;
    at_neg();
    chk("idle_busy", busy, 1'b0);
    chk("idle_kw_ready", kw_ready, 1'b0);
    chk("kernel_held", kernel, exp_kernel);
    next();
  endtask

  task automatic run_frame(input bit seq, input bit bubbles, input bit poke);
    set_weights(seq);
    load_kernel(poke);
    issue_windows(W * H, bubbles, poke);
    drain_and_finish(poke);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; kw_valid = 0; kw_data = 0; win_valid = 0;
    s_start = 0; s_kw_valid = 0; s_kw_data = 0; s_win_valid = 0;
    #1 rst_n = 1'b0;
    repeat (2) begin at_neg(); next(); end
    check_reset_outputs("por");
    rst_n = 1'b1;
    next();

    // weights 1..9 with gaps, back-to-back windows
    run_frame(1'b1, 1'b0, 1'b0);
    // random weights, random window bubbles
    run_frame(1'b0, 1'b1, 1'b0);
    // start pulsed in every busy state; new frame reloads the kernel
    run_frame(1'b0, 1'b1, 1'b1);

    // reset in the middle of RUN after five windows
    set_weights(1'b0);
    load_kernel(1'b0);
    issue_windows(5, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_rst");
    exp_q.delete();
    res_k = 0;
    done_cyc = -1;
    exp_kernel = '0;
    repeat (2) begin win_valid = 1'b1; at_neg(); next(); end
    rst_n = 1'b1;
    for (int i = 0; i < L + 3; i++) begin
      win_valid = 1'b1;
      at_neg();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_win_ready", win_ready, 1'b0);
      chk("post_rst_mac_issue", mac_issue, 1'b0);
      next();
    end
    win_valid = 1'b0;
    run_frame(1'b0, 1'b1, 1'b0);

    // 1x1 frame with LAT=1
    s_start = 1'b1;
    at_neg();
    next();
    s_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_kw_valid = 1'b1;
      s_kw_data  = 16'(16'h100 + i);
      at_neg();
      chk("s_kw_ready", s_kw_ready, 1'b1);
      next();
    end
    s_kw_valid  = 1'b0;
    s_win_valid = 1'b1;
    at_neg();
    chk("s_win_ready", s_win_ready, 1'b1);
    chk("s_mac_issue", s_mac_issue, 1'b1);
    chk("s_out_valid_early", s_out_valid, 1'b0);
    chk("s_kernel_w0", s_kernel[15:0], 16'h100);
    chk("s_kernel_w8", s_kernel[143:128], 16'h108);
    next();
    at_neg();
    chk("s_mac_issue_after", s_mac_issue, 1'b0);
    chk("s_out_valid", s_out_valid, 1'b1);
    chk("s_out_row", s_out_row, 0);
    chk("s_out_col", s_out_col, 0);
    chk("s_done_early", s_done, 1'b0);
    next();
    s_win_valid = 1'b0;
    at_neg();
    chk("s_done", s_done, 1'b1);
    chk("s_out_valid_late", s_out_valid, 1'b0);
    next();
    at_neg();
    chk("s_busy_end", s_busy, 1'b0);
    chk("s_done_end", s_done, 1'b0);
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
